ip_sequencer_stack: RTL and testbench

Parametrised instruction-pointer sequencer with a multi-level return-address stack, successor to the single-register CALL/RET scheme in the MiniAlu pipeline. It generates the ROM fetch address each cycle and handles sequential advance, taken branches, nested CALL/RET up to a configurable depth, and pipeline stalls. Stack overflow and underflow are reported through sticky error flags. It sits between the decode stage's control signals (branch/call/return/target) and the instruction ROM address input.

---
 rtl/ip_sequencer_stack_if.sv | 32 +++
 rtl/ip_sequencer_stack.sv | 119 +++++++++++
 tb/tb_ip_sequencer_stack.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ip_sequencer_stack_if.sv
// Control bundle between the decode stage and the instruction-pointer sequencer.
// The decode side (master) issues commands and the sequencer (slave) returns fetch addresses and stack status.
interface ip_sequencer_stack_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int STACK_DEPTH = 4
) ();
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic                  iEnable;
  logic                  iBranchTaken;
  logic                  iCall;
  logic                  iReturn;
  logic [ADDR_WIDTH-1:0] iTarget;
  logic                  iClearErr;
  logic [ADDR_WIDTH-1:0] oIP;
  logic [ADDR_WIDTH-1:0] oNextIP;
  logic [DW-1:0]         oDepth;
  logic                  oEmpty;
  logic                  oFull;
  logic                  oOverflow;
  logic                  oUnderflow;

  modport master (
    output iEnable, iBranchTaken, iCall, iReturn, iTarget, iClearErr,
    input  oIP, oNextIP, oDepth, oEmpty, oFull, oOverflow, oUnderflow
  );

  modport slave (
    input  iEnable, iBranchTaken, iCall, iReturn, iTarget, iClearErr,
    output oIP, oNextIP, oDepth, oEmpty, oFull, oOverflow, oUnderflow
  );
endinterface

// File: rtl/ip_sequencer_stack.sv
// Instruction-pointer sequencer with a circular return-address stack.
// oNextIP is the combinational fetch address; oIP is its registered copy.
module ip_sequencer_stack #(
  parameter int ADDR_WIDTH   = 16,
  parameter int STACK_DEPTH  = 4,
  parameter int WRAP_ON_FULL = 0
) (
  input logic                 Clock,
  input logic                 Reset,
  ip_sequencer_stack_if.slave bus
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // Pointer wraps modulo STACK_DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    ptrInc = (p == PW'(STACK_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptrDec(input logic [PW-1:0] p);
    ptrDec = (p == '0) ? PW'(STACK_DEPTH - 1) : p - 1'b1;
  endfunction

  // Registered state (control, reset) and return-address storage (no reset).
  logic [ADDR_WIDTH-1:0] ip_p0;
  logic [DW-1:0]         depth_p0;
  logic [PW-1:0]         ptr_p0;       // next free slot; top is ptr_p0-1
  logic                  overflow_p0;
  logic                  underflow_p0;
  logic [ADDR_WIDTH-1:0] stackMem [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] nextIP;
  logic [ADDR_WIDTH-1:0] seqIP;
  logic [ADDR_WIDTH-1:0] topEntry;
  logic [DW-1:0]         nextDepth;
  logic [PW-1:0]         nextPtr;
  logic                  push;
  logic                  setOverflow;
  logic                  setUnderflow;
  logic                  isEmpty;
  logic                  isFull;

  assign seqIP    = ip_p0 + 1'b1;
  assign topEntry = stackMem[ptrDec(ptr_p0)];
  assign isEmpty  = (depth_p0 == '0);
  assign isFull   = (depth_p0 == DW'(STACK_DEPTH));

  // Command decode: RET beats CALL beats branch beats sequential advance.
  always_comb begin
    nextIP       = ip_p0;
    nextDepth    = depth_p0;
    nextPtr      = ptr_p0;
    push         = 1'b0;
    setOverflow  = 1'b0;
    setUnderflow = 1'b0;
    if (bus.iEnable) begin
      if (bus.iReturn) begin
        if (!isEmpty) begin
          nextIP    = topEntry;
          nextDepth = depth_p0 - 1'b1;
          nextPtr   = ptrDec(ptr_p0);
        end else begin
          nextIP       = seqIP;
          setUnderflow = 1'b1;
        end
      end else if (bus.iCall) begin
        nextIP = bus.iTarget;
        if (!isFull) begin
          push      = 1'b1;
          nextDepth = depth_p0 + 1'b1;
          nextPtr   = ptrInc(ptr_p0);
        end else begin
          setOverflow = 1'b1;
          // In circular mode the slot at the pointer holds the oldest entry.
          if (WRAP_ON_FULL != 0) begin
            push    = 1'b1;
            nextPtr = ptrInc(ptr_p0);
          end
        end
      end else if (bus.iBranchTaken) begin
        nextIP = bus.iTarget;
      end else begin
        nextIP = seqIP;
      end
    end
  end

  // Control state: IP, depth, pointer and sticky flags (set wins over clear).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ip_p0        <= '0;
      depth_p0     <= '0;
      ptr_p0       <= '0;
      overflow_p0  <= 1'b0;
      underflow_p0 <= 1'b0;
    end else begin
      ip_p0        <= nextIP;
      depth_p0     <= nextDepth;
      ptr_p0       <= nextPtr;
      overflow_p0  <= setOverflow  | (overflow_p0  & ~bus.iClearErr);
      underflow_p0 <= setUnderflow | (underflow_p0 & ~bus.iClearErr);
    end
  end

  // Return-address write; the stored value is the address after the CALL.
  always_ff @(posedge Clock) begin
    if (push) begin
      stackMem[ptr_p0] <= seqIP;
    end
  end

  assign bus.oIP        = ip_p0;
  assign bus.oNextIP    = nextIP;
  assign bus.oDepth     = depth_p0;
  assign bus.oEmpty     = isEmpty;
  assign bus.oFull      = isFull;
  assign bus.oOverflow  = overflow_p0;
  assign bus.oUnderflow = underflow_p0;
endmodule

// File: tb/tb_ip_sequencer_stack.sv
// Bench for ip_sequencer_stack: one drop-mode and one wrap-mode instance share stimulus.
module tb_ip_sequencer_stack;
  localparam int AW = 16;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ip_sequencer_stack_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) busD ();
  ip_sequencer_stack_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) busW ();

  ip_sequencer_stack #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .WRAP_ON_FULL(0)) dutDrop (
    .Clock(clk), .Reset(rst), .bus(busD)
  );
  ip_sequencer_stack #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .WRAP_ON_FULL(1)) dutWrap (
    .Clock(clk), .Reset(rst), .bus(busW)
  );

  typedef struct {
    logic          rst, en, br, cl, rt, clr;
    logic [AW-1:0] tgt;
    logic [AW-1:0] ipD;   // expected IP, drop-mode instance
    logic [AW-1:0] ipW;   // expected IP, wrap-mode instance
    logic [2:0]    dep;
    logic          ov, un;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   nCmp = 0;
  int   nBad = 0;

  function automatic vec_t mk(input logic r, en, br, cl, rt, clr,
                              input logic [AW-1:0] tgt, ipD, ipW,
                              input logic [2:0] dep, input logic ov, un);
    vec_t v;
    v.rst = r; v.en = en; v.br = br; v.cl = cl; v.rt = rt; v.clr = clr;
    v.tgt = tgt; v.ipD = ipD; v.ipW = ipW; v.dep = dep; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst;
    busD.iEnable = v.en; busD.iBranchTaken = v.br; busD.iCall = v.cl;
    busD.iReturn = v.rt; busD.iClearErr = v.clr; busD.iTarget = v.tgt;
    busW.iEnable = v.en; busW.iBranchTaken = v.br; busW.iCall = v.cl;
    busW.iReturn = v.rt; busW.iClearErr = v.clr; busW.iTarget = v.tgt;
    #1;
    if (!v.rst) begin
      chk("nextIP_drop", 32'(busD.oNextIP), 32'(v.ipD));
      chk("nextIP_wrap", 32'(busW.oNextIP), 32'(v.ipW));
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ip_drop",    32'(busD.oIP),        32'(e.ipD));
    chk("ip_wrap",    32'(busW.oIP),        32'(e.ipW));
    chk("depth_drop", 32'(busD.oDepth),     32'(e.dep));
    chk("depth_wrap", 32'(busW.oDepth),     32'(e.dep));
    chk("empty_drop", 32'(busD.oEmpty),     32'(e.dep == 0));
    chk("full_wrap",  32'(busW.oFull),      32'(e.dep == 3'(SD)));
    chk("full_drop",  32'(busD.oFull),      32'(e.dep == 3'(SD)));
    chk("ovf_drop",   32'(busD.oOverflow),  32'(e.ov));
    chk("ovf_wrap",   32'(busW.oOverflow),  32'(e.ov));
    chk("unf_drop",   32'(busD.oUnderflow), 32'(e.un));
    chk("unf_wrap",   32'(busW.oUnderflow), 32'(e.un));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    busD.iEnable = 0; busD.iBranchTaken = 0; busD.iCall = 0; busD.iReturn = 0;
    busD.iClearErr = 0; busD.iTarget = '0;
    busW.iEnable = 0; busW.iBranchTaken = 0; busW.iCall = 0; busW.iReturn = 0;
    busW.iClearErr = 0; busW.iTarget = '0;

    // Reset, sequential run, nested calls/returns
    tbl.push_back(mk(1,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    0,0,0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0,1,0,0,0,0, 16'h0, AW'(i), AW'(i), 0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0, 16'h10,   16'h10,   16'h10,   1,0,0));
    tbl.push_back(mk(0,1,0,1,0,0, 16'h20,   16'h20,   16'h20,   2,0,0));
    tbl.push_back(mk(0,1,0,1,0,0, 16'h30,   16'h30,   16'h30,   3,0,0));
    tbl.push_back(mk(0,1,0,1,0,0, 16'h40,   16'h40,   16'h40,   4,0,0));
    tbl.push_back(mk(0,1,0,0,1,0, 16'h0,    16'h31,   16'h31,   3,0,0));
    tbl.push_back(mk(0,1,0,0,1,0, 16'h0,    16'h21,   16'h21,   2,0,0));
    tbl.push_back(mk(0,1,0,0,1,0, 16'h0,    16'h11,   16'h11,   1,0,0));
    tbl.push_back(mk(0,1,0,0,1,0, 16'h0,    16'h6,    16'h6,    0,0,0));
    // Underflow, clear under stall, set-beats-clear
    tbl.push_back(mk(0,1,0,0,0,0, 16'h0,    16'h7,    16'h7,    0,0,0));
    tbl.push_back(mk(0,1,0,0,1,0, 16'h0,    16'h8,    16'h8,    0,0,1));
    tbl.push_back(mk(0,0,0,0,0,1, 16'h0,    16'h8,    16'h8,    0,0,0));
    tbl.push_back(mk(0,1,0,0,1,1, 16'h0,    16'h9,    16'h9,    0,0,1));
    tbl.push_back(mk(0,1,0,0,0,1, 16'h0,    16'hA,    16'hA,    0,0,0));
    // Stall with CALL held, CALL+RET, branch vs call/ret priority
    tbl.push_back(mk(0,1,0,1,0,0, 16'h100,  16'h100,  16'h100,  1,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,1,0,0, 16'h200, 16'h100, 16'h100, 1,0,0));
    tbl.push_back(mk(0,1,0,1,1,0, 16'h200,  16'hB,    16'hB,    0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0, 16'h1234, 16'h1234, 16'h1234, 0,0,0));
    tbl.push_back(mk(0,1,1,1,0,0, 16'h300,  16'h300,  16'h300,  1,0,0));
    tbl.push_back(mk(0,1,1,0,1,0, 16'h400,  16'h1235, 16'h1235, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 16'h0,    16'h1235, 16'h1235, 0,0,0));
    foreach (tbl[i]) step(tbl[i]);

    // Address wrap at 0xFFFF, and a CALL from 0xFFFF returning to 0
    step(mk(0,1,1,0,0,0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0,0,0));
    step(mk(0,1,0,0,0,0, 16'h0,    16'h0,    16'h0,    0,0,0));
    step(mk(0,1,1,0,0,0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0,0,0));
    step(mk(0,1,0,1,0,0, 16'h20,   16'h20,   16'h20,   1,0,0));
    step(mk(0,1,0,0,1,0, 16'h0,    16'h0,    16'h0,    0,0,0));

    // Overflow: drop keeps originals, wrap replaces the oldest with 0x51
    step(mk(1,0,0,0,0,0, 16'h0, 16'h0, 16'h0, 0,0,0));
    for (int i = 1; i <= 5; i++)
      step(mk(0,1,0,0,0,0, 16'h0, AW'(i), AW'(i), 0,0,0));
    step(mk(0,1,0,1,0,0, 16'h10, 16'h10, 16'h10, 1,0,0));
    step(mk(0,1,0,1,0,0, 16'h20, 16'h20, 16'h20, 2,0,0));
    step(mk(0,1,0,1,0,0, 16'h30, 16'h30, 16'h30, 3,0,0));
    step(mk(0,1,0,1,0,0, 16'h40, 16'h40, 16'h40, 4,0,0));
    step(mk(0,1,1,0,0,0, 16'h50, 16'h50, 16'h50, 4,0,0));
    step(mk(0,1,0,1,0,0, 16'h50, 16'h50, 16'h50, 4,1,0));
    step(mk(0,1,0,0,1,0, 16'h0,  16'h31, 16'h51, 3,1,0));
    step(mk(0,1,0,0,1,0, 16'h0,  16'h21, 16'h31, 2,1,0));
    step(mk(0,1,0,0,1,0, 16'h0,  16'h11, 16'h21, 1,1,0));
    step(mk(0,1,0,0,1,0, 16'h0,  16'h6,  16'h11, 0,1,0));
    step(mk(0,1,0,0,1,0, 16'h0,  16'h7,  16'h12, 0,1,1));
    step(mk(0,0,0,0,0,1, 16'h0,  16'h7,  16'h12, 0,0,0));

    // Reset in the middle of a call chain
    step(mk(0,1,0,1,0,0, 16'h80, 16'h80, 16'h80, 1,0,0));
    step(mk(0,1,0,1,0,0, 16'h90, 16'h90, 16'h90, 2,0,0));
    step(mk(1,1,0,1,0,0, 16'hA0, 16'h0,  16'h0,  0,0,0));
    step(mk(0,1,0,0,0,0, 16'h0,  16'h1,  16'h1,  0,0,0));
    step(mk(0,1,0,0,1,0, 16'h0,  16'h2,  16'h2,  0,0,1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
